matrix_scan: RTL and testbench

Row-scanning display driver for the 8x8 playfield produced by the `tetris` core. It captures `map0`..`map7` into a frame buffer only at frame boundaries, so the display never tears. It then drives one row at a time onto an LED matrix, with a configurable blanking interval at the start of each row slot to suppress ghosting. It sits between the game core's map outputs and the board's row/column pins.

---
 rtl/matrix_scan_if.sv | 17 +
 rtl/matrix_scan.sv | 59 +++++
 tb/tb_matrix_scan.sv | 135 +++++++++++++
 3 files changed

// File: rtl/matrix_scan_if.sv
// matrix_scan_if: playfield rows and freeze from the game core, row/column drive back out.
interface matrix_scan_if;
  logic [7:0] map0, map1, map2, map3, map4, map5, map6, map7;
  logic       freeze;
  logic [7:0] row_en;
  logic [7:0] col;
  logic [2:0] row_idx;
  logic       frame_start;
  modport master (
    output map0, map1, map2, map3, map4, map5, map6, map7, freeze,
    input  row_en, col, row_idx, frame_start
  );
  modport slave (
    input  map0, map1, map2, map3, map4, map5, map6, map7, freeze,
    output row_en, col, row_idx, frame_start
  );
endinterface

// File: rtl/matrix_scan.sv
// matrix_scan: row-scanning LED matrix driver with a frame buffer that loads only at frame wraps.
module matrix_scan #(
  parameter int DIV   = 1250,
  parameter int BLANK = 2
) (
  input logic          CLK,
  input logic          CLR,
  matrix_scan_if.slave bus
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_q, row_d;
  logic [7:0]    fb_q [8];
  logic [7:0]    fb_d [8];
  logic [7:0]    map [8];
  logic          first_q, wrap, load, dark;
  logic [7:0]    row_en_q, row_en_d, col_q, col_d;
  logic [2:0]    row_idx_q;
  logic          frame_start_q, frame_start_d;
  assign map = '{bus.map0, bus.map1, bus.map2, bus.map3, bus.map4, bus.map5, bus.map6, bus.map7};
  // Outputs decode the next-state counters so they line up with the registered counters.
  always_comb begin
    wrap          = cnt_q == LAST;
    cnt_d         = wrap ? '0 : cnt_q + 1'b1;
    row_d         = wrap ? row_q + 3'd1 : row_q;
    load          = first_q || (wrap && row_q == 3'd7 && !bus.freeze);
    for (int i = 0; i < 8; i++) fb_d[i] = load ? map[i] : fb_q[i];
    dark          = int'(cnt_d) < BLANK;
    row_en_d      = dark ? 8'h00 : 8'h01 << row_d;
    col_d         = dark ? 8'h00 : fb_d[row_d];
    frame_start_d = row_d == 3'd0 && cnt_d == '0;
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt_q         <= '0;
      row_q         <= '0;
      first_q       <= 1'b1;
      fb_q          <= '{default: '0};
      row_en_q      <= '0;
      col_q         <= '0;
      row_idx_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      first_q       <= 1'b0;
      fb_q          <= fb_d;
      row_en_q      <= row_en_d;
      col_q         <= col_d;
      row_idx_q     <= row_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign bus.row_en      = row_en_q;
  assign bus.col         = col_q;
  assign bus.row_idx     = row_idx_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: two scan configurations checked cycle by cycle against a frame/slot arithmetic model.
module tb_matrix_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] m [8];
  logic       frz;
  matrix_scan_if ia ();
  matrix_scan_if ib ();
  assign ia.map0 = m[0]; assign ia.map1 = m[1]; assign ia.map2 = m[2]; assign ia.map3 = m[3];
  assign ia.map4 = m[4]; assign ia.map5 = m[5]; assign ia.map6 = m[6]; assign ia.map7 = m[7];
  assign ib.map0 = m[0]; assign ib.map1 = m[1]; assign ib.map2 = m[2]; assign ib.map3 = m[3];
  assign ib.map4 = m[4]; assign ib.map5 = m[5]; assign ib.map6 = m[6]; assign ib.map7 = m[7];
  assign ia.freeze = frz;
  assign ib.freeze = frz;
  matrix_scan #(.DIV(4), .BLANK(1)) dut_a (.CLK(clk), .CLR(rst), .bus(ia.slave));
  matrix_scan #(.DIV(2), .BLANK(0)) dut_b (.CLK(clk), .CLR(rst), .bus(ib.slave));
  typedef struct packed {
    logic [7:0] row_en;
    logic [7:0] col;
    logic [2:0] row_idx;
    logic       fs;
  } exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int checks = 0, passed = 0, t = 0;
  logic [7:0] fa [8];
  logic [7:0] fbm [8];
  // t counts cycles since reset release; slot and row follow from t alone.
  function automatic exp_t predict(int tt, int d, int b, logic [7:0] f [8]);
    exp_t e;
    int c = tt % d;
    int r = (tt / d) % 8;
    logic dk = c < b;
    e.row_en  = dk ? 8'h00 : 8'(1 << r);
    e.col     = dk ? 8'h00 : f[r];
    e.row_idx = 3'(r);
    e.fs      = (tt % (8 * d)) == 0;
    return e;
  endfunction
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at t=%0d: got %h expected %h", nm, t, act, exp);
  endtask
  task automatic zero_chk(string tag);
    chk({tag, " a.row_en"}, ia.row_en, 8'h00);
    chk({tag, " a.col"}, ia.col, 8'h00);
    chk({tag, " a.row_idx"}, 8'(ia.row_idx), 8'h00);
    chk({tag, " a.frame_start"}, 8'(ia.frame_start), 8'h00);
    chk({tag, " b.row_en"}, ib.row_en, 8'h00);
    chk({tag, " b.col"}, ib.col, 8'h00);
    chk({tag, " b.row_idx"}, 8'(ib.row_idx), 8'h00);
    chk({tag, " b.frame_start"}, 8'(ib.frame_start), 8'h00);
  endtask
  // Buffers load on the first edge after release and at each frame boundary unless frozen.
  task automatic step();
    @(posedge clk);
    t++;
    if (t == 1 || (t % 32 == 0 && !frz)) fa = m;
    if (t == 1 || (t % 16 == 0 && !frz)) fbm = m;
    qa.push_back(predict(t, 4, 1, fa));
    qb.push_back(predict(t, 2, 0, fbm));
    #1;
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a.row_en", ia.row_en, ea.row_en);
      chk("a.col", ia.col, ea.col);
      chk("a.row_idx", 8'(ia.row_idx), 8'(ea.row_idx));
      chk("a.frame_start", 8'(ia.frame_start), 8'(ea.fs));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b.row_en", ib.row_en, eb.row_en);
      chk("b.col", ib.col, eb.col);
      chk("b.row_idx", 8'(ib.row_idx), 8'(eb.row_idx));
      chk("b.frame_start", 8'(ib.frame_start), 8'(eb.fs));
    end
  end
  initial begin
    frz = 1'b1;
    for (int i = 0; i < 8; i++) m[i] = 8'($urandom);
    m[0] = 8'b10000001;
    m[1] = 8'b01111110;
    m[2] = 8'h0F;
    m[5] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_chk("in_reset");
    rst = 1'b0;
    t = 0;
    #1 zero_chk("release");
    step();
    frz = 1'b0;
    while (t < 5) step();
    m[5] = 8'hFF;
    while (t < 58) step();
    frz = 1'b1;
    while (t < 62) step();
    m[2] = 8'hF0;
    while (t < 70) step();
    frz = 1'b0;
    while (t < 130) step();
    repeat (600) begin
      if ($urandom_range(0, 2) == 0) m[$urandom_range(0, 7)] = 8'($urandom);
      frz = $urandom_range(0, 3) == 0;
      step();
    end
    frz = 1'b0;
    while (t % 32 != 14) step();
    @(negedge clk);
    rst = 1'b1;
    #1 zero_chk("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    frz = 1'b1;
    rst = 1'b0;
    t = 0;
    #1 zero_chk("rerelease");
    step();
    frz = 1'b0;
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) m[$urandom_range(0, 7)] = 8'($urandom);
      step();
    end
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
